// File: rtl/monitor_pkg.sv
// monitor_pkg: FSM encoding and counter helper shared by the store monitor files.
package monitor_pkg;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_PASS  = 3'd3;
   localparam logic [2:0] ST_FAIL  = 3'd4;
   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN,
      PASS  = ST_PASS,
      FAIL  = ST_FAIL
   } state_e;
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/store_match.sv
// store_match: same-cycle compare of one store against one pass-pattern channel.
module store_match #(
   parameter int WIDTH = 64
) (
   input  logic             store,
   input  logic             en,
   input  logic [WIDTH-1:0] dataadr,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] data,
   output logic             hit
);
   assign hit = store && en && dataadr == adr && writedata == data;
endmodule

// File: rtl/store_monitor.sv
// store_monitor: watches stores for configured pass patterns, reports pass after a drain delay
// or fail on run-cycle timeout.
module store_monitor
   import monitor_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int NCHK       = 4,
   parameter int TIMEOUT    = 1580,
   parameter int STOP_DELAY = 10,
   parameter int ORDERED    = 0
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       start,
   input  logic [1:0]                                 memwrite,
   input  logic [WIDTH-1:0]                           dataadr,
   input  logic [WIDTH-1:0]                           writedata,
   input  logic                                       cfg_we,
   input  logic [$clog2(NCHK > 1 ? NCHK : 2)-1:0]     cfg_idx,
   input  logic [WIDTH-1:0]                           cfg_adr,
   input  logic [WIDTH-1:0]                           cfg_data,
   input  logic                                       cfg_en,
   output logic [2:0]                                 state,
   output logic                                       pass,
   output logic                                       fail,
   output logic                                       done,
   output logic [$clog2(NCHK > 1 ? NCHK : 2)-1:0]     pass_id,
   output logic [31:0]                                cycles,
   output logic [31:0]                                stores
);
   localparam int IW = $clog2(NCHK > 1 ? NCHK : 2);
   state_e           st;
   logic [WIDTH-1:0] tab_adr [NCHK];
   logic [WIDTH-1:0] tab_dat [NCHK];
   logic [NCHK-1:0]  en, hit;
   logic [IW-1:0]    ptr, first_en, next_en, hit_low, win_id;
   logic [31:0]      cnt;
   logic             store, cfg_ok, last, any_hit, ptr_hit, win;
   assign store   = |memwrite;
   assign state   = st;
   assign cfg_ok  = st == IDLE && cfg_we && int'(cfg_idx) < NCHK;
   assign ptr_hit = hit[ptr];
   assign win     = ORDERED != 0 ? ptr_hit && last : any_hit;
   assign win_id  = ORDERED != 0 ? ptr : hit_low;
   for (genvar i = 0; i < NCHK; i++) begin : g_ch
      store_match #(.WIDTH(WIDTH)) u_match (
         .store(store), .en(en[i]), .dataadr(dataadr), .writedata(writedata),
         .adr(tab_adr[i]), .data(tab_dat[i]), .hit(hit[i])
      );
   end
   // Descending scans leave the lowest qualifying index in each result.
   always_comb begin
      first_en = '0;
      next_en  = ptr;
      last     = 1'b1;
      hit_low  = '0;
      any_hit  = 1'b0;
      for (int i = NCHK - 1; i >= 0; i--) begin
         if (en[i]) first_en = IW'(i);
         if (en[i] && i > int'(ptr)) begin
            next_en = IW'(i);
            last    = 1'b0;
         end
         if (hit[i]) begin
            hit_low = IW'(i);
            any_hit = 1'b1;
         end
      end
   end
   always_ff @(posedge clk)
      if (!reset && cfg_ok) begin
         tab_adr[cfg_idx] <= cfg_adr;
         tab_dat[cfg_idx] <= cfg_data;
      end
   always_ff @(posedge clk)
      if (reset) begin
         st      <= IDLE;
         pass    <= 1'b0;
         fail    <= 1'b0;
         done    <= 1'b0;
         pass_id <= '0;
         cycles  <= '0;
         stores  <= '0;
         cnt     <= '0;
         ptr     <= '0;
         en      <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (cfg_ok) en[cfg_idx] <= cfg_en;
               if (start) begin
                  st     <= RUN;
                  cycles <= '0;
                  stores <= '0;
                  ptr    <= first_en;
               end
            end
            RUN: begin
               if (store) stores <= sat_inc(stores);
               if (ORDERED != 0 && ptr_hit && !last) ptr <= next_en;
               // A qualifying match beats a timeout landing on the same cycle.
               if (win) begin
                  pass_id <= win_id;
                  if (STOP_DELAY == 0) begin
                     st   <= PASS;
                     pass <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     st  <= DRAIN;
                     cnt <= 32'(STOP_DELAY);
                  end
               end else if (cycles >= 32'(TIMEOUT - 1)) begin
                  st   <= FAIL;
                  fail <= 1'b1;
                  done <= 1'b1;
               end else cycles <= sat_inc(cycles);
            end
            DRAIN: begin
               if (store) stores <= sat_inc(stores);
               cnt <= cnt - 32'd1;
               if (cnt <= 32'd1) begin
                  st   <= PASS;
                  pass <= 1'b1;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: directed and randomized runs on unordered and ordered monitors,
// checked against a channel-list reference model.
module tb_store_monitor;
   localparam int NCH  = 4;
   localparam int TO   = 1580;
   localparam int SD   = 10;
   localparam int MAXJ = TO + SD + 8;
   logic        clk = 1'b0;
   logic        reset, start, cfg_we, cfg_en;
   logic [1:0]  memwrite, cfg_idx;
   logic [63:0] dataadr, writedata, cfg_adr, cfg_data;
   logic [2:0]  st [2];
   logic        ps [2], fl [2], dn [2];
   logic [1:0]  pid [2];
   logic [31:0] cy [2], sr [2];
   int          n_checks = 0, n_errors = 0;
   logic [63:0] c_adr [NCH], c_dat [NCH];
   bit          c_en [NCH];
   logic [1:0]  s_mw [MAXJ], s_ci [MAXJ];
   logic [63:0] s_a [MAXJ], s_d [MAXJ];
   bit          s_start [MAXJ], s_cwe [MAXJ];
   always #5 clk = ~clk;
   store_monitor #(.ORDERED(0)) u_any (
      .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
      .cfg_data(cfg_data), .cfg_en(cfg_en), .state(st[0]), .pass(ps[0]), .fail(fl[0]),
      .done(dn[0]), .pass_id(pid[0]), .cycles(cy[0]), .stores(sr[0])
   );
   store_monitor #(.ORDERED(1)) u_ord (
      .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
      .cfg_data(cfg_data), .cfg_en(cfg_en), .state(st[1]), .pass(ps[1]), .fail(fl[1]),
      .done(dn[1]), .pass_id(pid[1]), .cycles(cy[1]), .stores(sr[1])
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs;
      start = 0; memwrite = 0; cfg_we = 0; cfg_idx = 0; cfg_en = 0;
      dataadr = 0; writedata = 0; cfg_adr = 0; cfg_data = 0;
   endtask
   task automatic do_reset;
      idle_inputs;
      reset = 1;
      tick;
      reset = 0;
      foreach (c_en[c]) c_en[c] = 0;
   endtask
   task automatic cfg(input int idx, input logic [63:0] a, input logic [63:0] d, input bit e);
      cfg_we = 1; cfg_idx = 2'(idx); cfg_adr = a; cfg_data = d; cfg_en = e;
      tick;
      cfg_we = 0;
      c_adr[idx] = a; c_dat[idx] = d; c_en[idx] = e;
   endtask
   task automatic clear_stream;
      for (int j = 0; j < MAXJ; j++) begin
         s_mw[j] = 0; s_a[j] = 0; s_d[j] = 0; s_start[j] = 0; s_cwe[j] = 0; s_ci[j] = 0;
      end
   endtask
   task automatic put(input int j, input logic [63:0] a, input logic [63:0] d);
      s_mw[j] = 2'd1; s_a[j] = a; s_d[j] = d;
   endtask
   task automatic check_idle(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s/%0d/state", tag, d), 64'(st[d]), 0);
         check($sformatf("%s/%0d/pass", tag, d), 64'(ps[d]), 0);
         check($sformatf("%s/%0d/fail", tag, d), 64'(fl[d]), 0);
         check($sformatf("%s/%0d/done", tag, d), 64'(dn[d]), 0);
         check($sformatf("%s/%0d/pass_id", tag, d), 64'(pid[d]), 0);
         check($sformatf("%s/%0d/cycles", tag, d), 64'(cy[d]), 0);
         check($sformatf("%s/%0d/stores", tag, d), 64'(sr[d]), 0);
      end
   endtask
   function automatic bit hits(input int j, input int c);
      return c_en[c] && s_mw[j] != 0 && s_a[j] == c_adr[c] && s_d[j] == c_dat[c];
   endfunction
   // Reference: first winning run cycle, winning channel, cycles until done, stores counted.
   task automatic model(input bit ord, output int kp, output int id, output int k_end, output int n_st);
      int order[$];
      int pos, last_k;
      pos = 0; kp = -1; id = 0; n_st = 0;
      for (int c = 0; c < NCH; c++) if (c_en[c]) order.push_back(c);
      for (int k = 0; k < TO && kp < 0; k++) begin
         if (!ord) begin
            for (int c = NCH - 1; c >= 0; c--) if (hits(k, c)) begin kp = k; id = c; end
         end else if (order.size() > 0 && hits(k, order[pos])) begin
            if (pos == order.size() - 1) begin kp = k; id = order[pos]; end
            else pos++;
         end
      end
      last_k = kp >= 0 ? kp + SD : TO - 1;
      k_end  = last_k + 1;
      for (int j = 0; j <= last_k; j++) if (s_mw[j] != 0) n_st++;
   endtask
   task automatic run_test(input string name);
      int kp [2], id [2], ke [2], ns [2], done_at [2];
      for (int d = 0; d < 2; d++) model(bit'(d), kp[d], id[d], ke[d], ns[d]);
      start = 1;
      tick;
      start = 0;
      done_at = '{-1, -1};
      for (int j = 0; j < MAXJ && (done_at[0] < 0 || done_at[1] < 0); j++) begin
         memwrite = s_mw[j]; dataadr = s_a[j]; writedata = s_d[j]; start = s_start[j];
         cfg_we = s_cwe[j]; cfg_idx = s_ci[j]; cfg_adr = s_a[j]; cfg_data = s_d[j]; cfg_en = 1;
         tick;
         for (int d = 0; d < 2; d++) if (done_at[d] < 0 && dn[d]) done_at[d] = j + 1;
      end
      idle_inputs;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s/%0d/done_at", name, d), 64'(done_at[d]), 64'(ke[d]));
         check($sformatf("%s/%0d/state", name, d), 64'(st[d]), kp[d] >= 0 ? 3 : 4);
         check($sformatf("%s/%0d/pass", name, d), 64'(ps[d]), 64'(kp[d] >= 0));
         check($sformatf("%s/%0d/fail", name, d), 64'(fl[d]), 64'(kp[d] < 0));
         check($sformatf("%s/%0d/done", name, d), 64'(dn[d]), 1);
         check($sformatf("%s/%0d/cycles", name, d), 64'(cy[d]), 64'(kp[d] >= 0 ? kp[d] : TO - 1));
         check($sformatf("%s/%0d/stores", name, d), 64'(sr[d]), 64'(ns[d]));
         if (kp[d] >= 0) check($sformatf("%s/%0d/pass_id", name, d), 64'(pid[d]), 64'(id[d]));
      end
   endtask
   task automatic rand_run(input int r);
      logic [63:0] pa [4], pd [4];
      do_reset;
      for (int i = 0; i < 4; i++) begin
         pa[i] = {$urandom, $urandom};
         pd[i] = {$urandom, $urandom};
      end
      for (int c = 0; c < NCH; c++)
         if ($urandom_range(0, 3) != 0)
            cfg(c, pa[$urandom_range(0, 3)], pd[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      for (int j = 0; j < MAXJ; j++) begin
         s_mw[j]    = $urandom_range(0, 1) != 0 ? 2'($urandom_range(1, 3)) : 2'd0;
         s_a[j]     = pa[$urandom_range(0, 3)];
         s_d[j]     = pd[$urandom_range(0, 3)] ^ ($urandom_range(0, 7) == 0 ? 64'h8000_0000_0000_0000 : 64'd0);
         s_start[j] = $urandom_range(0, 31) == 0;
         s_cwe[j]   = $urandom_range(0, 15) == 0;
         s_ci[j]    = 2'($urandom_range(0, 3));
      end
      run_test($sformatf("rand%0d", r));
   endtask
   initial begin
      idle_inputs;
      reset = 1;
      repeat (3) tick;
      reset = 0;
      check_idle("reset");
      do_reset; cfg(0, 100, 7, 1); clear_stream;
      put(40, 100, 7);
      run_test("match40");
      do_reset; cfg(0, 508, 7, 1); cfg(2, 80, 1, 1); clear_stream;
      put(12, 80, 1); put(14, 508, 7); put(16, 508, 7); put(30, 80, 1); put(35, 80, 1);
      run_test("lowest_id");
      do_reset; cfg(0, 100, 7, 1); clear_stream;
      for (int j = 0; j < MAXJ; j += 3) put(j, 100, 8);
      run_test("timeout");
      do_reset; cfg(0, 320, 4950, 1); cfg(1, 100, 7, 1); clear_stream;
      put(5, 100, 7); put(8, 320, 4950); put(12, 100, 7);
      run_test("ordered");
      do_reset; cfg(0, 100, 7, 1); clear_stream;
      put(TO - 2, 100, 8); put(TO - 1, 100, 7);
      run_test("edge_timeout");
      do_reset; cfg(0, 64'h8000_0000_0000_0064, 7, 0); clear_stream;
      for (int j = 0; j < MAXJ; j += 2) put(j, j % 4 == 0 ? 64'd100 : 64'h8000_0000_0000_0064, 7);
      run_test("no_enable");
      do_reset; cfg(0, 100, 7, 1); clear_stream;
      s_cwe[3] = 1; s_ci[3] = 2'd1; s_a[3] = 200; s_d[3] = 9; s_start[10] = 1;
      put(6, 200, 9); put(20, 100, 7);
      run_test("cfg_in_run");
      do_reset; cfg(0, 100, 7, 1);
      start = 1; tick; start = 0;
      repeat (5) tick;
      memwrite = 1; dataadr = 100; writedata = 7;
      tick;
      idle_inputs;
      for (int d = 0; d < 2; d++) check($sformatf("drain_in/%0d/state", d), 64'(st[d]), 2);
      repeat (5) tick;
      for (int d = 0; d < 2; d++) check($sformatf("drain_5/%0d/state", d), 64'(st[d]), 2);
      reset = 1; tick; reset = 0;
      check_idle("abort");
      repeat (20) tick;
      check_idle("abort_hold");
      for (int r = 0; r < 16; r++) rand_run(r);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
